// File: rtl/mac_pkg.sv
// Shared state type and default sizing for the MAC operand arbiter.
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
  import mac_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % NREQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin burst arbiter feeding operand pairs from NREQ requesters into one multiplier.
//   state | meaning
//   IDLE  | no grant; pick next requester from rr_ptr
//   BURST | one requester granted, up to BURST beats
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int BURST = DEF_BURST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_d1,
  input  logic [NREQ*WIDTH-1:0]   req_d2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_d1,
  output logic [WIDTH-1:0]        out_d2,
  output logic [$clog2(NREQ)-1:0] out_src,
  output logic                    busy
);

  localparam int            IW        = $clog2(NREQ);
  localparam int            CW        = 4;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    gnt_q, rr_ptr_q, pick_idx, ptr_next;
  logic [CW-1:0]    cnt_q;
  logic             pick_any, in_burst, stall, gnt_valid;
  logic             xfer, last_xfer, drop, exit_burst;
  logic [WIDTH-1:0] sel_d1, sel_d2;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign in_burst   = (state_q == mac_pkg::BURST);
  assign stall      = out_valid & ~out_ready;
  assign gnt_valid  = req_valid[gnt_q];
  assign xfer       = in_burst & gnt_valid & ~stall;
  assign last_xfer  = xfer & (cnt_q == LAST_BEAT);
  // A stalled output holds the burst open even if the requester lets valid go.
  assign drop       = in_burst & ~gnt_valid & ~stall;
  assign exit_burst = last_xfer | drop;
  assign ptr_next   = (gnt_q == LAST_REQ) ? '0 : gnt_q + IW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= mac_pkg::IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      mac_pkg::IDLE:  if (pick_any)   state_d = mac_pkg::BURST;
      mac_pkg::BURST: if (exit_burst) state_d = mac_pkg::IDLE;
      default:                        state_d = mac_pkg::IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (in_burst) begin
      busy             = 1'b1;
      req_ready[gnt_q] = ~stall;
    end
  end

  always_comb begin
    sel_d1 = '0;
    sel_d2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IW'(i)) begin
        sel_d1 = req_d1[i*WIDTH +: WIDTH];
        sel_d2 = req_d2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (state_q == mac_pkg::IDLE && pick_any) begin
        gnt_q <= pick_idx;
        cnt_q <= '0;
      end else if (xfer) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (exit_burst) rr_ptr_q <= ptr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_d1    <= sel_d1;
      out_d2    <= sel_d2;
      out_src   <= gnt_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Scoreboard bench for mac_arbiter: directed arbitration scenarios plus a long random run.
module tb_mac_arbiter;

  localparam int W     = 4;
  localparam int N     = 4;
  localparam int B     = 4;
  localparam int IW    = 2;
  localparam int BOUND = (N - 1) * (B + 1) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_d1, req_d2;
  logic           out_valid, out_ready, busy;
  logic [W-1:0]   out_d1, out_d2;
  logic [IW-1:0]  out_src;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
  } beat_t;

  beat_t         sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            seq[N];
  logic [N-1:0]  vld;
  logic          ordy;
  bit            fix_data;
  bit            fired;
  logic [IW-1:0] fired_src;
  int            n_fired;
  bit            wait_chk;
  int            wt[N];
  int            max_wt;
  logic [N-1:0]  xfer_mask;

  always #5 clk = ~clk;

  mac_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_d1    (req_d1),
    .req_d2    (req_d2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_src   (out_src),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] d1_of(int i, int s);
    return fix_data ? W'(3) : W'(s + 3 * i);
  endfunction

  function automatic logic [W-1:0] d2_of(int i, int s);
    return fix_data ? W'(5) : W'(5 * s + i + 1);
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_d1"},    out_d1,    0);
    check_eq({tag, "_out_d2"},    out_d2,    0);
    check_eq({tag, "_out_src"},   out_src,   0);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_req_ready"}, req_ready, 0);
  endtask

  // Drive this cycle's inputs, then sample and score at the falling edge.
  task automatic step_a();
    beat_t e;
    for (int i = 0; i < N; i++) begin
      req_d1[i*W +: W] = d1_of(i, seq[i]);
      req_d2[i*W +: W] = d2_of(i, seq[i]);
    end
    req_valid = vld;
    out_ready = ordy;
    @(negedge clk);
    fired     = out_valid & out_ready;
    fired_src = out_src;
    if (fired) begin
      n_fired++;
      check_eq("sb_has_beat", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("out_src", out_src, e.src);
        check_eq("out_d1",  out_d1,  e.d1);
        check_eq("out_d2",  out_d2,  e.d2);
      end
    end
    xfer_mask = req_valid & req_ready;
    if (xfer_mask != '0) check_eq("one_grant", int'($onehot(xfer_mask)), 1);
    for (int i = 0; i < N; i++) begin
      if (xfer_mask[i]) begin
        e.src = IW'(i);
        e.d1  = d1_of(i, seq[i]);
        e.d2  = d2_of(i, seq[i]);
        sb.push_back(e);
      end
    end
    if (wait_chk) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          wt[i]++;
          if (wt[i] > max_wt) max_wt = wt[i];
        end else begin
          wt[i] = 0;
        end
      end
    end
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xfer_mask[i]) seq[i]++;
  endtask

  task automatic do_reset();
    vld       = '0;
    req_valid = '0;
    ordy      = 1'b1;
    out_ready = 1'b1;
    reset     = 1'b1;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    sb.delete();
    xfer_mask = '0;
    n_fired   = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  h_d1, h_d2;
    logic [IW-1:0] h_src;
    int            nf;
    int            n_src1;

    reset     = 1'b0;
    vld       = '0;
    ordy      = 1'b1;
    fix_data  = 1'b0;
    wait_chk  = 1'b0;
    max_wt    = 0;
    req_valid = '0;
    out_ready = 1'b1;
    req_d1    = '0;
    req_d2    = '0;
    xfer_mask = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      wt[i]  = 0;
    end
    #2;

    // All requesters valid: grants rotate 0,1,2,3 with four beats and one idle cycle each.
    do_reset();
    vld = '1;
    nf  = 0;
    for (int k = 0; k < 42; k++) begin
      step_a();
      check_eq("rr_busy", busy, int'((k % 5) != 0));
      check_eq("rr_ready", req_ready, ((k % 5) != 0) ? (1 << ((k / 5) % 4)) : 0);
      if (fired) begin
        check_eq("rr_src_order", fired_src, (nf / 4) % 4);
        nf++;
      end
      step_b();
    end

    // Single requester 2 with fixed operands: one-cycle latency, bubble every four beats.
    do_reset();
    fix_data = 1'b1;
    vld      = 4'b0100;
    for (int k = 0; k < 15; k++) begin
      step_a();
      check_eq("solo_busy", busy, int'((k % 5) != 0));
      if (k == 1) check_eq("solo_latency", out_valid, 0);
      if (k == 2) begin
        check_eq("solo_valid", out_valid, 1);
        check_eq("solo_d1",    out_d1,    3);
        check_eq("solo_d2",    out_d2,    5);
        check_eq("solo_src",   out_src,   2);
      end
      step_b();
    end
    fix_data = 1'b0;

    // Five-cycle output stall after two beats: everything holds, then the burst finishes.
    do_reset();
    vld = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      ordy = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
      step_a();
      if (k == 3) begin
        h_d1  = out_d1;
        h_d2  = out_d2;
        h_src = out_src;
      end
      if (k >= 3 && k <= 7) begin
        check_eq("stall_ready", req_ready, 0);
        check_eq("stall_busy",  busy,      1);
        check_eq("stall_valid", out_valid, 1);
      end
      if (k >= 4 && k <= 7) begin
        check_eq("stall_d1",  out_d1,  h_d1);
        check_eq("stall_d2",  out_d2,  h_d2);
        check_eq("stall_src", out_src, h_src);
      end
      if (k == 9) check_eq("stall_still_busy", busy, 1);
      if (k == 10) begin
        check_eq("stall_exit", busy,    0);
        check_eq("stall_beats", n_fired, 4);
      end
      step_b();
    end

    // Requester 1 drops valid after two beats: pointer moves on and requester 2 wins next.
    do_reset();
    vld    = 4'b0110;
    n_src1 = 0;
    for (int k = 0; k < 6; k++) begin
      vld = (k == 3) ? 4'b0100 : 4'b0110;
      step_a();
      if (fired && fired_src == 1) n_src1++;
      if (k == 3) begin
        check_eq("drop_busy",  busy,      1);
        check_eq("drop_ready", req_ready, 4'b0010);
      end
      if (k == 4) begin
        check_eq("drop_idle",       busy,      0);
        check_eq("drop_idle_ready", req_ready, 0);
      end
      if (k == 5) begin
        check_eq("drop_next_busy",  busy,      1);
        check_eq("drop_next_grant", req_ready, 4'b0100);
      end
      step_b();
    end
    check_eq("drop_beats_src1", n_src1, 2);

    // Reset during the third beat: outputs clear at once, no ghost beat, pointer back to 0.
    do_reset();
    vld = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step_a();
      step_b();
    end
    step_a();
    check_eq("mid_rst_beat3_ready", req_ready, 4'b0001);
    reset = 1'b1;
    #1;
    check_zero("mid_rst");
    sb.delete();
    xfer_mask = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    vld = '0;
    for (int k = 0; k < 3; k++) begin
      step_a();
      check_eq("no_ghost", out_valid, 0);
      step_b();
    end
    vld = 4'b0011;
    step_a();
    step_b();
    step_a();
    check_eq("ptr_after_rst", req_ready, 4'b0001);
    step_b();

    // Random valids with out_ready held high: ordering plus the grant wait bound.
    do_reset();
    wait_chk = 1'b1;
    max_wt   = 0;
    vld      = N'($urandom);
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) vld[i] = ~vld[i];
      step_a();
      step_b();
    end
    wait_chk = 1'b0;
    check_eq("wait_bound", int'(max_wt <= BOUND), 1);
    check_eq("wait_seen", int'(max_wt > 0), 1);

    // Random valids and random back-pressure: ordering and data integrity only.
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) vld[i] = ~vld[i];
      ordy = ($urandom_range(0, 3) != 0);
      step_a();
      step_b();
    end
    vld  = '0;
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step_a();
      step_b();
    end
    check_eq("sb_drained", sb.size(), 0);
    check_eq("drained_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
